bit_set_sequencer: RTL and testbench
====================================

Name: bit_set_sequencer

Overview:
- Batch controller for the bit-set datapath (acc | (1 << index)).
- Requesters queue signed-magnitude bit indices through a valid/ready port, load a base word, then start a run.
- The block applies one queued index per clock to an internal accumulator, aborts on the first illegal index and reports completion, error and applied count.
- Sits between the command/stimulus side and the result register of the ALU-style datapath.

Parameters:
N, 8, data and index width; index MSB is sign, bits [N-2:0] are magnitude
DEPTH, 4, index queue depth (power of two, >= 2)

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
in_base  input  N  base word captured by in_load
in_load  input  1  load accumulator with in_base, clear o_ERR and o_count
in_idx  input  N  bit index, sign-magnitude
in_idx_valid  input  1  in_idx valid
o_idx_ready  output  1  queue accepts in_idx this cycle
in_start  input  1  start a run over all queued indices
o_busy  output  1  run in progress (states RUN, FLUSH)
o_done  output  1  one-cycle completion pulse
o_out  output  N  accumulator value
o_ERR  output  1  sticky error flag for the last run
o_count  output  $clog2(DEPTH+1)  indices successfully applied in the last run

Behaviour:
- One clock. Reset is asynchronous and active-low: i_rst_n low forces all state immediately. Outputs after reset: o_out=0, o_ERR=0, o_count=0, o_done=0, o_busy=0, queue empty, state IDLE. o_idx_ready=1 once reset is released.
- Index legality: illegal if sign=1 or magnitude >= N. A legal index applies acc <= acc | (1 << magnitude).
- Push: accepted when in_idx_valid && o_idx_ready. o_idx_ready = (state==IDLE) && !full. No push is accepted in any other state.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - in_load: acc <= in_base, o_ERR <= 0, o_count <= 0.
  - in_start: o_ERR <= 0, o_count <= 0. If the queue is empty, go to DONE; otherwise go to RUN.
  - load and start in the same cycle: both are honoured; the run operates on the new base.
  - push and start in the same cycle: the pushed entry is part of the run.
- RUN: pop the head each cycle.
  - Legal entry: update acc and increment o_count. Go to DONE if it was the last entry; otherwise stay in RUN.
  - Illegal entry: acc holds, o_ERR <= 1, go to FLUSH.
- FLUSH: reset the queue pointers (empty in one cycle), go to DONE.
- DONE: o_done=1 for exactly this cycle, then go to IDLE. o_done is decoded from the state register.
- Latency: with K legal entries, o_done is high in the cycle after the K-th rising edge following the edge that sampled in_start. Empty queue: high in the cycle after the start edge. Error at entry j: high in the cycle after edge j+1.
- in_load and in_start are ignored outside IDLE.
- o_out, o_ERR and o_count hold between runs.
- Reset mid-run discards the queue and the accumulator.

Optional Feature:
- Macro BIT_SEQ_SKIP_ERR_EN.
- Defined: an illegal index is skipped (acc holds, o_ERR <= 1, o_count unchanged), the run continues through the remaining entries, and FLUSH is never entered.
- Undefined: abort-and-flush behaviour as above.

Decomposition:
- Package bit_seq_pkg: state enum (IDLE, RUN, FLUSH, DONE) and an index-legality function parameterised by N.
- Sign and magnitude extraction use the shared macro header.
- One natural sub-module, idx_fifo: synchronous FIFO with push/pop/clear and full/empty flags, sized DEPTH x N.

Test Plan:
- N=8, DEPTH=4:
  - Load 0x00; push 1, 3, 7; start. Required: o_done 3 cycles after start, o_out=0x8A, o_ERR=0, o_count=3.
  - Load 0x00; push 2, 0x85, 4; start. Required: o_out=0x04, o_ERR=1, o_count=1, queue empty after done, index 4 not applied. With BIT_SEQ_SKIP_ERR_EN: o_out=0x14, o_ERR=1, o_count=2.
  - Push 0x08 (magnitude 8); start. Required: o_ERR=1, o_out unchanged.
  - Push 0, 1, 2, 3, then attempt 5. Required: o_idx_ready=0 after the 4th push, 5th not accepted; run yields o_out=0x0F.
  - Load 0x5A; start with empty queue. Required: o_done in the next cycle, o_out=0x5A, o_ERR=0, o_count=0.
  - Pull i_rst_n low mid-RUN. Required: all outputs 0 immediately, o_busy=0, queue empty, o_idx_ready=1 after release.

Source files
------------

// File: rtl/bit_seq_pkg.sv
// Shared types, sign/magnitude macros and index-legality helper for the
// bit-set sequencer.
`ifndef BIT_SEQ_MACROS_SVH
`define BIT_SEQ_MACROS_SVH
// Sign bit and magnitude field of a w-bit sign-magnitude index.
`define BIT_SEQ_SIGN(x, w) x[(w)-1]
`define BIT_SEQ_MAG(x, w) x[(w)-2:0]
`endif

package bit_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush,
    StDone
  } state_e;

  // Legal when positive and the magnitude addresses a bit inside an n-bit word.
  function automatic logic idx_legal(input logic sign, input logic [31:0] mag,
                                     input int unsigned n);
    return !sign && (mag < n);
  endfunction

endpackage

// File: rtl/idx_fifo.sv
// Synchronous index queue: push/pop/clear with full/empty flags and a
// one-entry-left flag used to detect the final pop of a run.
module idx_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             one_left_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level;

  // Extra pointer MSB distinguishes full from empty.
  assign level      = wr_ptr_q - rd_ptr_q;
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign one_left_o = (level == PtrOne);
  assign rdata_o    = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state; clear wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i && !full_o) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop_i && !empty_o) rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o && !clear_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/bit_set_sequencer.sv
// Batch controller for the bit-set datapath: queues sign-magnitude indices,
// then ORs one bit per clock into an accumulator during a run.
// Build option BIT_SEQ_SKIP_ERR_EN: illegal indices are skipped and the run
// continues instead of aborting and flushing the queue.
module bit_set_sequencer
  import bit_seq_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [N-1:0]               in_base,
  input  logic                       in_load,
  input  logic [N-1:0]               in_idx,
  input  logic                       in_idx_valid,
  output logic                       o_idx_ready,
  input  logic                       in_start,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [N-1:0]               o_out,
  output logic                       o_ERR,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  state_e          state_q, state_d;
  logic [N-1:0]    acc_q, acc_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic         push, pop, clear;
  logic [N-1:0] head_idx;
  logic [N-2:0] head_mag;
  logic [N-1:0] one_hot;
  logic         head_legal;
  logic         fifo_full, fifo_empty, fifo_last;

  assign o_idx_ready = (state_q == StIdle) && !fifo_full;
  assign push        = in_idx_valid && o_idx_ready;
  assign pop         = (state_q == StRun);
  assign clear       = (state_q == StFlush);

  idx_fifo #(
    .Width(N),
    .Depth(DEPTH)
  ) u_idx_fifo (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .push_i    (push),
    .wdata_i   (in_idx),
    .pop_i     (pop),
    .clear_i   (clear),
    .rdata_o   (head_idx),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .one_left_o(fifo_last)
  );

  assign head_mag   = `BIT_SEQ_MAG(head_idx, N);
  assign one_hot    = {{(N-1){1'b0}}, 1'b1} << head_mag;
  assign head_legal = idx_legal(`BIT_SEQ_SIGN(head_idx, N), 32'(head_mag), N);

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_load) begin
          acc_d = in_base;
          err_d = 1'b0;
          cnt_d = '0;
        end
        if (in_start) begin
          err_d = 1'b0;
          cnt_d = '0;
          // A push in the start cycle joins the run.
          state_d = (fifo_empty && !push) ? StDone : StRun;
        end
      end
      StRun: begin
        if (fifo_empty) begin
          state_d = StDone;
        end else if (head_legal) begin
          acc_d   = acc_q | one_hot;
          cnt_d   = cnt_q + CntW'(1);
          state_d = fifo_last ? StDone : StRun;
        end else begin
          err_d = 1'b1;
`ifdef BIT_SEQ_SKIP_ERR_EN
          state_d = fifo_last ? StDone : StRun;
`else
          state_d = StFlush;
`endif
        end
      end
      StFlush: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and result registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_busy  = (state_q == StRun) || (state_q == StFlush);
  assign o_done  = (state_q == StDone);
  assign o_out   = acc_q;
  assign o_ERR   = err_q;
  assign o_count = cnt_q;

endmodule

// File: tb/tb_bit_set_sequencer.sv
// Directed bench for bit_set_sequencer (N=8, DEPTH=4).
module tb_bit_set_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_base = '0;
  logic       in_load = 1'b0;
  logic [7:0] in_idx = '0;
  logic       in_idx_valid = 1'b0;
  logic       o_idx_ready;
  logic       in_start = 1'b0;
  logic       o_busy, o_done, o_ERR;
  logic [7:0] o_out;
  logic [2:0] o_count;

  int errors = 0;
  int checks = 0;

  bit_set_sequencer #(.N(8), .DEPTH(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .in_base     (in_base),
    .in_load     (in_load),
    .in_idx      (in_idx),
    .in_idx_valid(in_idx_valid),
    .o_idx_ready (o_idx_ready),
    .in_start    (in_start),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_out       (o_out),
    .o_ERR       (o_ERR),
    .o_count     (o_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] base);
    in_base = base;
    in_load = 1'b1;
    tick();
    in_load = 1'b0;
  endtask

  task automatic do_push(input logic [7:0] idx);
    in_idx       = idx;
    in_idx_valid = 1'b1;
    tick();
    in_idx_valid = 1'b0;
  endtask

  // Pulses start; lat = edges after the start edge until o_done (99 on timeout).
  task automatic do_start(output int lat);
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    lat = 0;
    while (o_done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    if (o_done !== 1'b1) lat = 99;
  endtask

  task automatic test_reset();
    #23;
    checks++; if (o_out !== 8'h00) begin errors++; $display("FAIL reset_out got %h want 00", o_out); end
    checks++; if (o_ERR !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", o_ERR); end
    checks++; if (o_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", o_count); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", o_done); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
    rst_n = 1'b1;
    #1;
    checks++; if (o_idx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", o_idx_ready); end
    tick();
  endtask

  task automatic test_legal_run();
    int lat;
    do_load(8'h00);
    do_push(8'd1); do_push(8'd3); do_push(8'd7);
    do_start(lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL legal_latency got %0d want 3", lat); end
    checks++; if (o_out !== 8'h8A) begin errors++; $display("FAIL legal_out got %h want 8a", o_out); end
    checks++; if (o_ERR !== 1'b0) begin errors++; $display("FAIL legal_err got %b want 0", o_ERR); end
    checks++; if (o_count !== 3'd3) begin errors++; $display("FAIL legal_count got %0d want 3", o_count); end
    tick();
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b want 0", o_done); end
    checks++; if (o_out !== 8'h8A) begin errors++; $display("FAIL legal_out_hold got %h want 8a", o_out); end
  endtask

  task automatic test_abort();
    int lat;
    do_load(8'h00);
    do_push(8'd2); do_push(8'h85); do_push(8'd4);
    do_start(lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL abort_latency got %0d want 3", lat); end
`ifdef BIT_SEQ_SKIP_ERR_EN
    checks++; if (o_out !== 8'h14) begin errors++; $display("FAIL abort_out got %h want 14", o_out); end
    checks++; if (o_count !== 3'd2) begin errors++; $display("FAIL abort_count got %0d want 2", o_count); end
`else
    checks++; if (o_out !== 8'h04) begin errors++; $display("FAIL abort_out got %h want 04", o_out); end
    checks++; if (o_count !== 3'd1) begin errors++; $display("FAIL abort_count got %0d want 1", o_count); end
`endif
    checks++; if (o_ERR !== 1'b1) begin errors++; $display("FAIL abort_err got %b want 1", o_ERR); end
    tick();
    // Queue must be empty: a fresh start completes immediately.
    do_start(lat);
    checks++; if (lat != 0) begin errors++; $display("FAIL abort_queue_empty got lat %0d want 0", lat); end
    checks++; if (o_ERR !== 1'b0) begin errors++; $display("FAIL start_clears_err got %b want 0", o_ERR); end
    tick();
  endtask

  task automatic test_mag_oob();
    int lat;
    do_load(8'h21);
    do_push(8'h08);
    do_start(lat);
`ifdef BIT_SEQ_SKIP_ERR_EN
    checks++; if (lat != 1) begin errors++; $display("FAIL oob_latency got %0d want 1", lat); end
`else
    checks++; if (lat != 2) begin errors++; $display("FAIL oob_latency got %0d want 2", lat); end
`endif
    checks++; if (o_ERR !== 1'b1) begin errors++; $display("FAIL oob_err got %b want 1", o_ERR); end
    checks++; if (o_out !== 8'h21) begin errors++; $display("FAIL oob_out got %h want 21", o_out); end
    checks++; if (o_count !== 3'd0) begin errors++; $display("FAIL oob_count got %0d want 0", o_count); end
    tick();
  endtask

  task automatic test_full();
    int lat;
    do_load(8'h00);
    do_push(8'd0); do_push(8'd1); do_push(8'd2); do_push(8'd3);
    checks++; if (o_idx_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", o_idx_ready); end
    do_push(8'd5);
    checks++; if (o_idx_ready !== 1'b0) begin errors++; $display("FAIL full_ready_hold got %b want 0", o_idx_ready); end
    do_start(lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL full_latency got %0d want 4", lat); end
    checks++; if (o_out !== 8'h0F) begin errors++; $display("FAIL full_out got %h want 0f", o_out); end
    checks++; if (o_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", o_count); end
    tick();
  endtask

  task automatic test_empty_start();
    int lat;
    do_load(8'h5A);
    do_start(lat);
    checks++; if (lat != 0) begin errors++; $display("FAIL empty_latency got %0d want 0", lat); end
    checks++; if (o_out !== 8'h5A) begin errors++; $display("FAIL empty_out got %h want 5a", o_out); end
    checks++; if (o_ERR !== 1'b0) begin errors++; $display("FAIL empty_err got %b want 0", o_ERR); end
    checks++; if (o_count !== 3'd0) begin errors++; $display("FAIL empty_count got %0d want 0", o_count); end
    tick();
  endtask

  // Load, push and start in one cycle: run uses the new base and the pushed entry.
  task automatic test_same_cycle();
    int lat;
    in_base = 8'h40; in_load = 1'b1;
    in_idx = 8'd2; in_idx_valid = 1'b1;
    in_start = 1'b1;
    tick();
    in_load = 1'b0; in_idx_valid = 1'b0; in_start = 1'b0;
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL same_busy got %b want 1", o_busy); end
    // Load during the run must be ignored.
    in_base = 8'hFF; in_load = 1'b1;
    lat = 0;
    while (o_done !== 1'b1 && lat < 20) begin tick(); lat++; end
    in_load = 1'b0;
    checks++; if (lat != 1) begin errors++; $display("FAIL same_latency got %0d want 1", lat); end
    checks++; if (o_out !== 8'h44) begin errors++; $display("FAIL same_out got %h want 44", o_out); end
    checks++; if (o_count !== 3'd1) begin errors++; $display("FAIL same_count got %0d want 1", o_count); end
    tick();
  endtask

  task automatic test_reset_midrun();
    int lat;
    do_load(8'h33);
    do_push(8'd1); do_push(8'd2); do_push(8'd3);
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    tick();
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got %b want 1", o_busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (o_out !== 8'h00) begin errors++; $display("FAIL midrun_out got %h want 00", o_out); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL midrun_busy_rst got %b want 0", o_busy); end
    checks++; if (o_count !== 3'd0) begin errors++; $display("FAIL midrun_count got %0d want 0", o_count); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL midrun_done got %b want 0", o_done); end
    #2;
    rst_n = 1'b1;
    #1;
    checks++; if (o_idx_ready !== 1'b1) begin errors++; $display("FAIL midrun_ready got %b want 1", o_idx_ready); end
    tick();
    do_start(lat);
    checks++; if (lat != 0) begin errors++; $display("FAIL midrun_queue_empty got lat %0d want 0", lat); end
    checks++; if (o_out !== 8'h00) begin errors++; $display("FAIL midrun_acc_cleared got %h want 00", o_out); end
    tick();
  endtask

  initial begin
    test_reset();
    test_legal_run();
    test_abort();
    test_mag_oob();
    test_full();
    test_empty_start();
    test_same_cycle();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
